// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the coordinate type used by the
// VGA timing generator and its axis counters.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus active/sync decode of the
// position that becomes current on the coming edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FRONT  = VGA_H_FRONT,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BACK   = VGA_H_BACK
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   advance,
  output coord_t count,
  output logic   wrap,
  output logic   active,
  output logic   sync
);

  localparam int          TOTAL      = ACTIVE + FRONT + SYNC + BACK;
  localparam coord_t      LAST       = coord_t'(TOTAL - 1);
  localparam logic [10:0] ACTIVE_END = 11'(ACTIVE);
  localparam logic [10:0] SYNC_BEG   = 11'(ACTIVE + FRONT);
  localparam logic [10:0] SYNC_END   = 11'(ACTIVE + FRONT + SYNC);

  coord_t count_q;
  coord_t count_d;

  // Decode uses count_d so the top can register its ports on the same edge
  // the counter moves, keeping ports aligned with the position.
  always_comb begin
    wrap    = advance && (count_q == LAST);
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (advance) begin
      count_d = count_q + coord_t'(1);
    end
    active = ({1'b0, count_d} < ACTIVE_END);
    sync   = ({1'b0, count_d} >= SYNC_BEG) && ({1'b0, count_d} < SYNC_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sync pulses, masked pixel coordinates,
// line/frame start strobes and a completed-frame counter, all registered.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic         clock25MHz,
  input  logic         reset,
  output logic         hsync,
  output logic         vsync,
  output logic         canDisplayImage,
  output coord_t       x,
  output coord_t       y,
  output logic         lineStart,
  output logic         frameStart,
  output logic [7:0]   frameCount
);

  localparam int H_LEN = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_LEN = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_LEN > 1024) begin : g_h_len_check
    $error("vga_timing_gen: horizontal total exceeds 1024");
  end
  if (V_LEN > 1024) begin : g_v_len_check
    $error("vga_timing_gen: vertical total exceeds 1024");
  end

  coord_t h_count, v_count;
  logic   h_wrap, h_active, h_sync;
  logic   v_wrap, v_active, v_sync;

  logic       run_q, run_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       disp_q, disp_d;
  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       line_q, line_d;
  logic       frame_st_q, frame_st_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // run_q holds the counters at (0,0) for the first edge after reset so that
  // edge presents position 0 rather than position 1.
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk(clock25MHz), .rst(reset), .advance(run_q),
    .count(h_count), .wrap(h_wrap), .active(h_active), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk(clock25MHz), .rst(reset), .advance(h_wrap),
    .count(v_count), .wrap(v_wrap), .active(v_active), .sync(v_sync)
  );

  always_comb begin
    run_d       = 1'b1;
    frame_cnt_d = v_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
    disp_d      = h_active && v_active;
    x_d         = disp_d ? h_count : '0;
    y_d         = disp_d ? v_count : '0;
    hsync_d     = h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d     = v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    line_d      = (h_count == '0);
    frame_st_d  = (h_count == '0) && (v_count == '0);
  end

  always_ff @(posedge clock25MHz or posedge reset) begin
    if (reset) begin
      run_q       <= 1'b0;
      hsync_q     <= ~SYNC_ACTIVE;
      vsync_q     <= ~SYNC_ACTIVE;
      disp_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      line_q      <= 1'b0;
      frame_st_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      run_q       <= run_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      disp_q      <= disp_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_q      <= line_d;
      frame_st_q  <= frame_st_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign canDisplayImage = disp_q;
  assign x               = x_q;
  assign y               = y_q;
  assign lineStart       = line_q;
  assign frameStart      = frame_st_q;
  assign frameCount      = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default geometry, a sync-polarity/front-porch
// override and a tiny raster for frame wrap, against an arithmetic model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic       hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0, y0;
  logic [7:0] fc0;
  logic       hs1, vs1, de1, ls1, fs1;
  logic [9:0] x1, y1;
  logic [7:0] fc1;
  logic       hs2, vs2, de2, ls2, fs2;
  logic [9:0] x2, y2;
  logic [7:0] fc2;

  obs_t act_def, act_ovr, act_small;
  assign act_def   = {hs0, vs0, de0, x0, y0, ls0, fs0, fc0};
  assign act_ovr   = {hs1, vs1, de1, x1, y1, ls1, fs1, fc1};
  assign act_small = {hs2, vs2, de2, x2, y2, ls2, fs2, fc2};

  vga_timing_gen u_def (
    .clock25MHz(clk), .reset(rst), .hsync(hs0), .vsync(vs0),
    .canDisplayImage(de0), .x(x0), .y(y0), .lineStart(ls0),
    .frameStart(fs0), .frameCount(fc0)
  );

  vga_timing_gen #(.H_FRONT(20), .SYNC_ACTIVE(1'b1)) u_ovr (
    .clock25MHz(clk), .reset(rst), .hsync(hs1), .vsync(vs1),
    .canDisplayImage(de1), .x(x1), .y(y1), .lineStart(ls1),
    .frameStart(fs1), .frameCount(fc1)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_small (
    .clock25MHz(clk), .reset(rst), .hsync(hs2), .vsync(vs2),
    .canDisplayImage(de2), .x(x2), .y(y2), .lineStart(ls2),
    .frameStart(fs2), .frameCount(fc2)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position k after release, computed from raster rules.
  function automatic obs_t model(input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input logic sa, input longint kk);
    longint ht, vt, h, line, v, frame;
    obs_t o;
    ht    = longint'(ha + hf + hsw + hb);
    vt    = longint'(va + vf + vsw + vb);
    h     = kk % ht;
    line  = kk / ht;
    v     = line % vt;
    frame = line / vt;
    o.de  = (h < ha) && (v < va);
    o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? sa : ~sa;
    o.vs  = (v >= va + vf && v < va + vf + vsw) ? sa : ~sa;
    o.x   = o.de ? 10'(h) : 10'd0;
    o.y   = o.de ? 10'(v) : 10'd0;
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    o.fc  = 8'(frame % 256);
    return o;
  endfunction

  function automatic obs_t model_def(input longint kk);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, kk);
  endfunction

  function automatic obs_t model_ovr(input longint kk);
    return model(640, 20, 96, 48, 480, 10, 2, 33, 1'b1, kk);
  endfunction

  function automatic obs_t model_small(input longint kk);
    return model(S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0, kk);
  endfunction

  function automatic obs_t reset_obs(input logic sa);
    obs_t o;
    o    = '0;
    o.hs = ~sa;
    o.vs = ~sa;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
                     o.hs, o.vs, o.de, o.x, o.y, o.ls, o.fs, o.fc);
  endfunction

  // Driver: returns on a falling edge with reset low; the next rising edge is k=0.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (act_def !== reset_obs(1'b0)) begin
      failures++;
      $display("FAIL reset_def got {%s} want {%s}", fmt(act_def), fmt(reset_obs(1'b0)));
    end
    checks++;
    if (act_ovr !== reset_obs(1'b1)) begin
      failures++;
      $display("FAIL reset_ovr got {%s} want {%s}", fmt(act_ovr), fmt(reset_obs(1'b1)));
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({de0, x0, y0, ls0, fs0, fc0, hs0, vs0} !== {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL edge0 got {%s} want de=1 x=0 y=0 ls=1 fs=1 fc=0 hs=1 vs=1", fmt(act_def));
    end
  endtask

  task automatic test_first_line();
    logic hs_exp;
    do_reset(3);
    for (int kk = 0; kk <= 800; kk++) begin
      @(negedge clk);
      hs_exp = (kk >= 656 && kk < 752) ? 1'b0 : 1'b1;
      checks++;
      if (hs0 !== hs_exp) begin
        failures++;
        $display("FAIL line_hsync k=%0d got %b want %b", kk, hs0, hs_exp);
      end
      checks++;
      if (de0 !== (kk < 640 || kk == 800)) begin
        failures++;
        $display("FAIL line_de k=%0d got %b want %b", kk, de0, (kk < 640 || kk == 800));
      end
      checks++;
      if (x0 !== ((kk < 640) ? 10'(kk) : 10'd0)) begin
        failures++;
        $display("FAIL line_x k=%0d got %0d want %0d", kk, x0, (kk < 640) ? kk : 0);
      end
      checks++;
      if (ls0 !== (kk == 0 || kk == 800)) begin
        failures++;
        $display("FAIL line_start k=%0d got %b want %b", kk, ls0, (kk == 0 || kk == 800));
      end
    end
    checks++;
    if (y0 !== 10'd1) begin
      failures++;
      $display("FAIL line2_y got %0d want 1", y0);
    end
  endtask

  task automatic test_override();
    int h;
    logic hs_exp;
    do_reset(2);
    for (int kk = 0; kk < 1700; kk++) begin
      @(negedge clk);
      h = kk % 804;
      hs_exp = (h >= 660 && h < 756) ? 1'b1 : 1'b0;
      checks++;
      if (hs1 !== hs_exp) begin
        failures++;
        $display("FAIL ovr_hsync k=%0d got %b want %b", kk, hs1, hs_exp);
      end
      checks++;
      if (ls1 !== (h == 0)) begin
        failures++;
        $display("FAIL ovr_line_len k=%0d got %b want %b", kk, ls1, (h == 0));
      end
    end
  endtask

  // Checks all three instances against the model for n edges after release.
  task automatic run_model(input string tag, input int n);
    obs_t e;
    for (int kk = 0; kk < n; kk++) begin
      @(negedge clk);
      e = model_def(longint'(kk));
      checks++;
      if (act_def !== e) begin
        failures++;
        $display("FAIL %s_def k=%0d got {%s} want {%s}", tag, kk, fmt(act_def), fmt(e));
      end
      e = model_ovr(longint'(kk));
      checks++;
      if (act_ovr !== e) begin
        failures++;
        $display("FAIL %s_ovr k=%0d got {%s} want {%s}", tag, kk, fmt(act_ovr), fmt(e));
      end
      e = model_small(longint'(kk));
      checks++;
      if (act_small !== e) begin
        failures++;
        $display("FAIL %s_small k=%0d got {%s} want {%s}", tag, kk, fmt(act_small), fmt(e));
      end
      if (kk == 128 || kk == 32768) begin
        checks++;
        if ({fs2, fc2} !== {1'b1, (kk == 128) ? 8'd1 : 8'd0}) begin
          failures++;
          $display("FAIL %s_frame_wrap k=%0d got fs=%b fc=%0d want fs=1 fc=%0d",
                   tag, kk, fs2, fc2, (kk == 128) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_frames();
    do_reset(3);
    run_model("frames", 32900);
  endtask

  task automatic test_async_reset();
    int n;
    for (int it = 0; it < 4; it++) begin
      do_reset($urandom_range(1, 5));
      n = $urandom_range(400, 3000);
      run_model("restart", n);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (act_def !== reset_obs(1'b0)) begin
        failures++;
        $display("FAIL async_def n=%0d got {%s} want {%s}", n, fmt(act_def), fmt(reset_obs(1'b0)));
      end
      checks++;
      if (act_ovr !== reset_obs(1'b1)) begin
        failures++;
        $display("FAIL async_ovr n=%0d got {%s} want {%s}", n, fmt(act_ovr), fmt(reset_obs(1'b1)));
      end
      checks++;
      if (act_small !== reset_obs(1'b0)) begin
        failures++;
        $display("FAIL async_small n=%0d got {%s} want {%s}", n, fmt(act_small), fmt(reset_obs(1'b0)));
      end
    end
    do_reset(3);
    run_model("final", 900);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_first_line();
    test_override();
    test_frames();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
